// File: rtl/ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

  localparam int unsigned ILEN   = 32;
  localparam int unsigned IBYTES = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [ILEN-1:0] pc;
  } fetch_entry_t;

  // A fetch address must be word aligned and leave a full word inside memory.
  function automatic logic fetch_legal(input logic [ILEN-1:0] addr,
                                       input logic [ILEN-1:0] last_addr);
    return (addr[1:0] == 2'b00) && (addr <= last_addr);
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction memory port and decode handshake of the fetch controller.
interface ifetch_ctrl_if;
  import ifetch_pkg::*;

  logic [ILEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_data;
  logic            instr_valid;
  logic [ILEN-1:0] instr;
  logic [ILEN-1:0] instr_pc;
  logic            instr_ready;

  modport master (
    output imem_addr,
    input  imem_data,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/ifetch_ctrl_fifo.sv
// Fetch buffer: small FIFO of {instr, pc} entries with synchronous flush.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // Pushing into a full buffer is allowed only when the head leaves this cycle.
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, fetch buffering, redirects and fault capture.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  ifetch_ctrl_if.master       bus,
  output logic                fault,
  output logic [31:0]         fault_pc,
  output logic [31:0]         pc
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - IBYTES);
  localparam logic [31:0] PC_STEP = 32'(IBYTES);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic         fifo_push;
  logic         fifo_flush;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign pop = !fifo_empty && bus.instr_ready;

  assign push_entry.instr = bus.imem_data;
  assign push_entry.pc    = pc_q;

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Redirect outranks fetching; a full buffer still takes a word when the head pops.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (redirect_valid) begin
      fifo_flush = 1'b1;
      pc_d       = redirect_pc;
      state_d    = RUN;
    end else if (state_q == RUN && fetch_en && (!fifo_full || pop)) begin
      if (fetch_legal(pc_q, LAST_PC)) begin
        fifo_push = 1'b1;
        pc_d      = pc_q + PC_STEP;
      end else begin
        state_d    = FAULT;
        fault_pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

  assign fault    = (state_q == FAULT);
  assign fault_pc = fault_pc_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  localparam int unsigned MEMB  = 1024;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        rdy;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] pc;

  logic [31:0] mem [0:255];

  int n_vec = 0;
  int n_err = 0;

  ifetch_ctrl_if bus ();

  ifetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .MEM_BYTES  (MEMB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus.master),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .pc             (pc)
  );

  always #5 clk = ~clk;

  assign bus.imem_data   = (bus.imem_addr < 32'(MEMB)) ? mem[bus.imem_addr[9:2]] : 32'hDEAD_BEEF;
  assign bus.instr_ready = rdy;

  // Reference model: expected decode stream as a queue, plus PC and fault flags.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_fault_pc;

  task automatic model_reset();
    q.delete();
    m_pc       = 32'h0;
    m_fault    = 1'b0;
    m_fault_pc = 32'h0;
  endtask

  task automatic model_step();
    exp_t e;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (redirect_valid) begin
      q.delete();
      m_pc    = redirect_pc;
      m_fault = 1'b0;
    end else if (!m_fault && fetch_en && q.size() < DEPTH) begin
      if ((m_pc % 4 == 0) && (longint'(m_pc) + 4 <= longint'(MEMB))) begin
        e.pc   = m_pc;
        e.word = mem[m_pc[9:2]];
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end else begin
        m_fault    = 1'b1;
        m_fault_pc = m_pc;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rdy            = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rdy            = 1'b0;
    model_reset();
    #3;
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc); end
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    n_vec++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
    n_vec++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_vec++; if (fault_pc !== 32'h0) begin n_err++; $display("FAIL reset_fault_pc: got %h want 0", fault_pc); end
    n_vec++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_imem_addr: got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h0000_0f93;
    words[1] = 32'h00f0_0313;
    words[2] = 32'h001f_8f93;
    do_reset();
    fetch_en = 1'b1;
    rdy      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", i, bus.instr_valid); end
      n_vec++; if (bus.instr !== words[i]) begin n_err++; $display("FAIL seq_instr[%0d]: got %h want %h", i, bus.instr, words[i]); end
      n_vec++; if (bus.instr_pc !== 32'(4*i)) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.instr_pc, 32'(4*i)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en = 1'b1;
    rdy      = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (bus.instr_pc !== 32'h0 || bus.instr !== 32'h0000_0f93) begin
        n_err++; $display("FAIL bp_head_stable[%0d]: got %h/%h want 00000f93/0", i, bus.instr, bus.instr_pc);
      end
    end
    n_vec++; if (pc !== 32'h8) begin n_err++; $display("FAIL bp_pc_hold: got %h want 8", pc); end
    n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", bus.instr_valid); end
    rdy = 1'b1;
    tick();
    n_vec++; if (bus.instr_pc !== 32'h4) begin n_err++; $display("FAIL bp_release_pc1: got %h want 4", bus.instr_pc); end
    n_vec++; if (bus.instr !== 32'h00f0_0313) begin n_err++; $display("FAIL bp_release_instr1: got %h want 00f00313", bus.instr); end
    tick();
    n_vec++; if (bus.instr_pc !== 32'h8) begin n_err++; $display("FAIL bp_release_pc2: got %h want 8", bus.instr_pc); end
    n_vec++; if (bus.instr !== 32'h001f_8f93) begin n_err++; $display("FAIL bp_release_instr2: got %h want 001f8f93", bus.instr); end
  endtask

  // Continues from test_backpressure, where the buffer holds PCs 8 and 12.
  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h18;
    tick();
    redirect_valid = 1'b0;
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid_drop: got %b want 0", bus.instr_valid); end
    n_vec++; if (pc !== 32'h18) begin n_err++; $display("FAIL redir_pc: got %h want 18", pc); end
    tick();
    n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL redir_valid_n2: got %b want 1", bus.instr_valid); end
    n_vec++; if (bus.instr_pc !== 32'h18) begin n_err++; $display("FAIL redir_instr_pc: got %h want 18", bus.instr_pc); end
    n_vec++; if (bus.instr !== mem[6]) begin n_err++; $display("FAIL redir_instr: got %h want %h", bus.instr, mem[6]); end
  endtask

  task automatic test_fault_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL mis_valid: got %b want 0", bus.instr_valid); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL mis_fault_early: got %b want 0", fault); end
    tick();
    n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL mis_fault: got %b want 1", fault); end
    n_vec++; if (fault_pc !== 32'h102) begin n_err++; $display("FAIL mis_fault_pc: got %h want 102", fault_pc); end
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL mis_no_push: got %b want 0", bus.instr_valid); end
    tick();
    n_vec++; if (pc !== 32'h102) begin n_err++; $display("FAIL mis_pc_hold: got %h want 102", pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL clr_fault: got %b want 0", fault); end
    n_vec++; if (fault_pc !== 32'h102) begin n_err++; $display("FAIL clr_fault_pc_kept: got %h want 102", fault_pc); end
    tick();
    n_vec++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h10) begin
      n_err++; $display("FAIL clr_resume: got valid=%b pc=%h want 1/10", bus.instr_valid, bus.instr_pc);
    end
    n_vec++; if (bus.instr !== mem[4]) begin n_err++; $display("FAIL clr_resume_instr: got %h want %h", bus.instr, mem[4]); end
  endtask

  task automatic test_end_of_mem();
    rdy            = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3F8;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    n_vec++; if (pc !== 32'h400) begin n_err++; $display("FAIL eom_pc: got %h want 400", pc); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL eom_fault_full: got %b want 0", fault); end
    n_vec++; if (bus.instr_pc !== 32'h3F8) begin n_err++; $display("FAIL eom_head: got %h want 3f8", bus.instr_pc); end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL eom_fault: got %b want 1", fault); end
    n_vec++; if (fault_pc !== 32'h400) begin n_err++; $display("FAIL eom_fault_pc: got %h want 400", fault_pc); end
    n_vec++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h3FC) begin
      n_err++; $display("FAIL eom_drain: got valid=%b pc=%h want 1/3fc", bus.instr_valid, bus.instr_pc);
    end
    n_vec++; if (bus.instr !== mem[255]) begin n_err++; $display("FAIL eom_last_instr: got %h want %h", bus.instr, mem[255]); end
  endtask

  // Starts in FAULT with one entry pending, then repeats with a full buffer.
  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL arst_fault: got %b want 0", fault); end
    n_vec++; if (fault_pc !== 32'h0) begin n_err++; $display("FAIL arst_fault_pc: got %h want 0", fault_pc); end
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid_a: got %b want 0", bus.instr_valid); end
    @(negedge clk);
    rst_n    = 1'b1;
    fetch_en = 1'b1;
    rdy      = 1'b0;
    tick();
    tick();
    n_vec++; if (pc !== 32'h8 || bus.instr_valid !== 1'b1) begin
      n_err++; $display("FAIL arst_refill: got pc=%h valid=%b want 8/1", pc, bus.instr_valid);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid_b: got %b want 0", bus.instr_valid); end
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL arst_pc: got %h want 0", pc); end
    @(negedge clk);
    rst_n = 1'b1;
    rdy   = 1'b1;
    tick();
    n_vec++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== 32'h0000_0f93) begin
      n_err++; $display("FAIL arst_restart: got valid=%b %h/%h want 1 00000f93/0", bus.instr_valid, bus.instr, bus.instr_pc);
    end
  endtask

  task automatic test_random();
    int unsigned r;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      fetch_en       = ($urandom_range(0, 9) < 8);
      rdy            = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 99) < 8);
      r = $urandom_range(0, 9);
      case (r)
        0:       redirect_pc = 32'($urandom_range(0, 1023)) | 32'h1;
        1:       redirect_pc = 32'($urandom_range(1024, 8191)) & ~32'h3;
        2, 3:    redirect_pc = 32'h3E0 + 32'(4 * $urandom_range(0, 7));
        default: redirect_pc = 32'(4 * $urandom_range(0, 255));
      endcase
      tick();
      n_vec++; if (bus.instr_valid !== (q.size() > 0)) begin
        n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, bus.instr_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        n_vec++; if (bus.instr_pc !== q[0].pc || bus.instr !== q[0].word) begin
          n_err++; $display("FAIL rnd_head@%0d: got %h/%h want %h/%h", cyc, bus.instr, bus.instr_pc, q[0].word, q[0].pc);
        end
      end
      n_vec++; if (pc !== m_pc || bus.imem_addr !== m_pc) begin
        n_err++; $display("FAIL rnd_pc@%0d: got pc=%h addr=%h want %h", cyc, pc, bus.imem_addr, m_pc);
      end
      n_vec++; if (fault !== m_fault || fault_pc !== m_fault_pc) begin
        n_err++; $display("FAIL rnd_fault@%0d: got %b/%h want %b/%h", cyc, fault, fault_pc, m_fault, m_fault_pc);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0f93;
    mem[1] = 32'h00f0_0313;
    mem[2] = 32'h001f_8f93;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_fault_redirect();
    test_end_of_mem();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
